bit_serializer: RTL and testbench

Upstream feeder for the serial pattern-detector path. Accepts parallel words over a valid/ready handshake, buffers them in a small FIFO, and shifts them out one bit per clock on a single registered serial line that drives the detector's `data_in`. Back-to-back words stream with no gap bits. The line is held at a fixed idle level when no data is pending.

---
 rtl/bit_serializer.sv | 221 ++++++++++++++++++++++
 tb/tb_bit_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer
//
// Parallel-to-serial feeder for the pattern-detector path. Words arrive over a
// valid/ready handshake, wait in a small FIFO, and leave one bit per clock on a
// registered serial line. Consecutive words stream with no gap bits. When no
// bit is pending, the line sits at IDLE_LEVEL.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   DEPTH      FIFO entries (power of 2, >= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//   IDLE_LEVEL level driven on data_out when no data bit is valid
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   flush        synchronous clear of FIFO and shifter (beats push and pop)
//   in_data      word to serialize
//   in_valid     in_data is valid
//   in_ready     combinational: !full && !flush
//   data_out     registered serial bit, drives the detector data_in
//   bit_valid    registered: data_out carries a data bit
//   frame_start  registered: high during the first bit of each word
//   busy         registered: shifter is in SHIFT
//   fifo_level   words held in the FIFO, not counting the word in the shifter

module bit_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   data_out,
  output logic                   bit_valid,
  output logic                   frame_start,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [CntW-1:0] LastBit  = CntW'(WIDTH - 1);
  localparam logic [LvlW-1:0] LevelMax = LvlW'(DEPTH);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign full     = (level_q == LevelMax);
  assign empty    = (level_q == '0);
  // No look-ahead to a same-cycle pop: a full FIFO always refuses.
  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  // Storage is not reset; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter FSM
  // ---------------------------------------------------------------------------
  // cnt_q is the transmit-order index of the bit currently on data_out.
  // shreg_q holds the not-yet-sent bits, aligned so the next one to send sits
  // at the MSB (MSB_FIRST) or LSB (LSB first) end.
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             data_q, data_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             load;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    data_d        = IDLE_LEVEL;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    load          = 1'b0;

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      shreg_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            load = 1'b1;
          end
        end
        StShift: begin
          if (cnt_q != LastBit) begin
            data_d      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
            shreg_d     = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d       = cnt_q + CntW'(1);
            bit_valid_d = 1'b1;
            busy_d      = 1'b1;
          end else if (!empty) begin
            // Last bit on the line and another word waiting: reload now so the
            // next word follows with no idle bit.
            load = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    if (load) begin
      state_d       = StShift;
      cnt_d         = '0;
      data_d        = MSB_FIRST ? head[WIDTH-1] : head[0];
      shreg_d       = MSB_FIRST ? (head << 1) : (head >> 1);
      bit_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      busy_d        = 1'b1;
    end
  end

  assign pop = load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shreg_q       <= '0;
      data_q        <= IDLE_LEVEL;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      data_q        <= data_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign data_out    = data_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first instance carries most of the
// scenarios, a second LSB-first instance covers the transmit-order option.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_bit_serializer;

  logic       clk;
  logic       reset_n;
  logic       flush;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       data_out;
  logic       bit_valid;
  logic       frame_start;
  logic       busy;
  logic [2:0] fifo_level;

  logic [7:0] l_in_data;
  logic       l_in_valid;
  logic       l_in_ready;
  logic       l_data_out;
  logic       l_bit_valid;
  logic       l_frame_start;
  logic       l_busy;
  logic [2:0] l_fifo_level;

  int n_checks;
  int n_pass;

  logic [7:0] got_q [$];
  logic [7:0] col_cur;
  int         col_cnt;
  logic       seen_full;
  logic       drv_acc;
  int         drv_guard;
  logic       any_valid;

  bit_serializer #(
    .WIDTH      (8),
    .DEPTH      (4),
    .MSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  bit_serializer #(
    .WIDTH      (8),
    .DEPTH      (4),
    .MSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b0)
  ) u_dut_lsb (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_data     (l_in_data),
    .in_valid    (l_in_valid),
    .in_ready    (l_in_ready),
    .data_out    (l_data_out),
    .bit_valid   (l_bit_valid),
    .frame_start (l_frame_start),
    .busy        (l_busy),
    .fifo_level  (l_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Eight cycles of one word on the MSB-first line, starting at the next edge.
  task automatic expect_word(input logic [7:0] w, input bit drop_valid, input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (drop_valid && i == 0) in_valid = 1'b0;
      check($sformatf("%s data bit%0d", tag, i), data_out, w[7-i]);
      check($sformatf("%s valid bit%0d", tag, i), bit_valid, 1'b1);
      check($sformatf("%s fstart bit%0d", tag, i), frame_start, (i == 0));
      check($sformatf("%s busy bit%0d", tag, i), busy, 1'b1);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    flush      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    l_in_data  = '0;
    l_in_valid = 1'b0;

    // Reset state
    #1;
    check("reset data_out", data_out, 1'b0);
    check("reset bit_valid", bit_valid, 1'b0);
    check("reset frame_start", frame_start, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset fifo_level", fifo_level, 3'd0);
    check("reset in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single word 0x99
    in_data  = 8'h99;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single level after push", fifo_level, 3'd1);
    check("single not yet valid", bit_valid, 1'b0);
    expect_word(8'h99, 1'b0, "single");
    tick();
    check("single idle valid", bit_valid, 1'b0);
    check("single idle data", data_out, 1'b0);
    check("single idle busy", busy, 1'b0);
    check("single idle level", fifo_level, 3'd0);
    repeat (2) tick();

    // Back-to-back 0xA5, 0x3C
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_data  = 8'h3C;
    expect_word(8'hA5, 1'b1, "b2b first");
    expect_word(8'h3C, 1'b0, "b2b second");
    tick();
    check("b2b idle valid", bit_valid, 1'b0);
    repeat (2) tick();

    // Fill and backpressure with 0x01..0x06
    seen_full = 1'b0;
    col_cur   = '0;
    col_cnt   = 0;
    got_q.delete();
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          in_data   = 8'(k);
          in_valid  = 1'b1;
          drv_acc   = 1'b0;
          drv_guard = 0;
          while (!drv_acc && drv_guard < 200) begin
            drv_acc = in_ready;
            tick();
            drv_guard++;
          end
          check($sformatf("fill push %0d accepted", k), drv_acc, 1'b1);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 80; c++) begin
          tick();
          if (fifo_level == 3'd4) seen_full = 1'b1;
          check($sformatf("fill in_ready c%0d", c), in_ready, (fifo_level != 3'd4));
          if (bit_valid) begin
            if (frame_start) begin
              col_cur = '0;
              col_cnt = 0;
            end
            col_cur = {col_cur[6:0], data_out};
            col_cnt++;
            if (col_cnt == 8) got_q.push_back(col_cur);
          end
        end
      end
    join
    check("fill reached level 4", seen_full, 1'b1);
    check("fill word count", got_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("fill order %0d", k),
            (k < got_q.size()) ? {24'd0, got_q[k]} : 32'hdead, k + 1);
    end
    check("fill drained valid", bit_valid, 1'b0);

    // LSB-first instance, 0x01
    l_in_data  = 8'h01;
    l_in_valid = 1'b1;
    tick();
    l_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("lsb data bit%0d", i), l_data_out, (i == 0));
      check($sformatf("lsb valid bit%0d", i), l_bit_valid, 1'b1);
      check($sformatf("lsb fstart bit%0d", i), l_frame_start, (i == 0));
    end
    tick();
    check("lsb idle valid", l_bit_valid, 1'b0);

    // Flush on the 3rd bit of 0xFF with two words queued
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_data = 8'h12;
    tick();
    check("flush first bit fstart", frame_start, 1'b1);
    in_data = 8'h34;
    tick();
    in_valid = 1'b0;
    check("flush queued level", fifo_level, 3'd2);
    tick();
    check("flush 3rd bit data", data_out, 1'b1);
    check("flush 3rd bit valid", bit_valid, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h56;
    #1;
    check("flush in_ready low", in_ready, 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush data_out", data_out, 1'b0);
    check("flush bit_valid", bit_valid, 1'b0);
    check("flush frame_start", frame_start, 1'b0);
    check("flush busy", busy, 1'b0);
    check("flush fifo_level", fifo_level, 3'd0);
    any_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bit_valid) any_valid = 1'b1;
    end
    check("flush push dropped", any_valid, 1'b0);

    // Async reset mid-stream
    in_data  = 8'hC3;
    in_valid = 1'b1;
    tick();
    in_data = 8'h5A;
    tick();
    in_data = 8'h66;
    tick();
    in_valid = 1'b0;
    tick();
    check("areset busy before", busy, 1'b1);
    check("areset level before", fifo_level, 3'd2);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset data_out", data_out, 1'b0);
    check("areset bit_valid", bit_valid, 1'b0);
    check("areset frame_start", frame_start, 1'b0);
    check("areset busy", busy, 1'b0);
    check("areset fifo_level", fifo_level, 3'd0);
    check("areset in_ready", in_ready, 1'b1);
    in_data  = 8'h77;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("areset push ignored", fifo_level, 3'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    any_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bit_valid || busy || fifo_level != 3'd0) any_valid = 1'b1;
    end
    check("areset line idles", any_valid, 1'b0);
    in_data  = 8'h81;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_word(8'h81, 1'b0, "post-reset");
    tick();
    check("post-reset idle", bit_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
